// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED pattern controller: display modes,
// button bit positions and per-mode position wrap masks.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SWEEP   = 2'd1,
    MODE_COUNT   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam int BTN_NEXT    = 1;
  localparam int BTN_PREV    = 2;
  localparam int BTN_UP      = 3;
  localparam int BTN_DN      = 4;
  localparam int BTN_PAUSE   = 5;
  localparam int BTN_RESTART = 6;

  function automatic mode_e mode_step(mode_e m, logic fwd);
    logic [1:0] cur;
    cur = m;
    return fwd ? mode_e'(cur + 2'd1) : mode_e'(cur - 2'd1);
  endfunction

  // Each mode only walks the low bits of the shared 9-bit position.
  function automatic logic [8:0] pos_mask(mode_e m);
    case (m)
      MODE_SWEEP: return 9'h00F;
      MODE_COUNT: return 9'h0FF;
      default:    return 9'h1FF;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit button conditioner: 2-FF synchroniser, stability counter, and a
// registered one-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable,
  output logic press
);

  logic                  sync1;
  logic                  sync2;
  logic                  stable_d;
  logic [DEBOUNCE_W-1:0] cnt;
  logic [DEBOUNCE_W-1:0] cnt_inc;

  assign cnt_inc = cnt + DEBOUNCE_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      press    <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= din;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      // Accept the new level once it has disagreed for 2^DEBOUNCE_W-1 samples.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (&cnt_inc) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// Push-button driven LED sequencer: OFF / SWEEP / COUNT / BREATHE modes with
// adjustable step rate, pause and restart. The mode register is the FSM state.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_W = 16,
  parameter int TICK_LSB   = 20,
  parameter int PWM_W      = 8,
  parameter int SPEED_RST  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] btn,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       paused
);

  logic [6:0] stable;
  logic [6:0] press;

  for (genvar i = 0; i < 7; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_W(DEBOUNCE_W)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (btn[i]),
      .stable (stable[i]),
      .press  (press[i])
    );
  end

  logic unused_btn;
  assign unused_btn = ^{stable, press[0]};

  mode_e               mode_q, mode_n;
  logic [2:0]          speed_q, speed_n;
  logic                paused_q, paused_n;
  logic [8:0]          pos_q, pos_n;
  logic [TICK_LSB-1:0] presc_q, presc_n;
  logic [TICK_LSB-1:0] tick_max;
  logic [PWM_W-1:0]    pwm_q;
  logic                tick;
  logic [2:0]          sweep_idx;
  logic [7:0]          level;
  logic [7:0]          led_n;

  assign mode   = mode_q;
  assign paused = paused_q;

  // At most one event acts per cycle: restart > mode > speed > pause.
  always_comb begin
    mode_n   = mode_q;
    speed_n  = speed_q;
    paused_n = paused_q;
    pos_n    = pos_q;
    presc_n  = presc_q;
    tick     = 1'b0;
    tick_max = {TICK_LSB{1'b1}} >> speed_q;
    if (press[BTN_RESTART]) begin
      pos_n    = '0;
      presc_n  = '0;
      speed_n  = 3'(SPEED_RST);
      paused_n = 1'b0;
    end else if (press[BTN_NEXT] ^ press[BTN_PREV]) begin
      mode_n  = mode_step(mode_q, press[BTN_NEXT]);
      pos_n   = '0;
      presc_n = '0;
    end else if (press[BTN_UP] ^ press[BTN_DN]) begin
      if (press[BTN_UP] && speed_q != 3'd7) begin
        speed_n = speed_q + 3'd1;
        presc_n = '0;
      end else if (press[BTN_DN] && speed_q != 3'd0) begin
        speed_n = speed_q - 3'd1;
        presc_n = '0;
      end
    end else if (press[BTN_PAUSE]) begin
      paused_n = ~paused_q;
    end else if (!paused_q) begin
      if (presc_q == tick_max) begin
        presc_n = '0;
        tick    = 1'b1;
      end else begin
        presc_n = presc_q + TICK_LSB'(1);
      end
    end
    if (tick) begin
      pos_n = (pos_q + 9'd1) & pos_mask(mode_q);
    end
  end

  always_comb begin
    sweep_idx = pos_q[3] ? ~pos_q[2:0] : pos_q[2:0];
    level     = pos_q[8] ? ~pos_q[7:0] : pos_q[7:0];
    led_n     = 8'h00;
    case (mode_q)
      MODE_SWEEP:   led_n = 8'd1 << sweep_idx;
      MODE_COUNT:   led_n = pos_q[7:0];
      MODE_BREATHE: led_n = {8{pwm_q < PWM_W'(level)}};
      default:      led_n = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_SWEEP;
      speed_q  <= 3'(SPEED_RST);
      paused_q <= 1'b0;
      pos_q    <= '0;
      presc_q  <= '0;
      pwm_q    <= '0;
      led      <= 8'h00;
    end else begin
      mode_q   <= mode_n;
      speed_q  <= speed_n;
      paused_q <= paused_n;
      pos_q    <= pos_n;
      presc_q  <= presc_n;
      pwm_q    <= pwm_q + PWM_W'(1);
      led      <= led_n;
    end
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: per-cycle reference model, a table of button
// actions, hand-timed corner sequences and a randomized button phase.
module tb_led_pattern_ctrl;

  localparam int DW = 2;
  localparam int TL = 8;
  localparam int PW = 8;
  localparam int SR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] btn = '0;
  logic [7:0] led;
  logic [1:0] mode;
  logic       paused;

  led_pattern_ctrl #(
    .DEBOUNCE_W(DW), .TICK_LSB(TL), .PWM_W(PW), .SPEED_RST(SR)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn    (btn),
    .led    (led),
    .mode   (mode),
    .paused (paused)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Buttons: the value seen by the debouncer is the input two edges old; a bit
  // flips once three consecutive observed samples disagree with it; the press
  // pulse acts two edges after the debounced rise.
  logic [6:0] samp [4];
  logic [6:0] st   [3];
  logic [6:0] m_p, m_new;
  int         m_mode, m_speed, m_pos, m_phase, m_pwm, m_ns;
  bit         m_paused;
  logic [7:0] m_led;
  bit         model_en = 0;

  function automatic logic [7:0] led_of(int md, int p, int pwm);
    int i, lvl;
    case (md)
      1: begin
        i = p % 16;
        if (i > 7) i = 15 - i;
        return 8'(1 << i);
      end
      2: return 8'(p % 256);
      3: begin
        lvl = (p < 256) ? p : 511 - p;
        return (pwm < lvl) ? 8'hFF : 8'h00;
      end
      default: return 8'h00;
    endcase
  endfunction

  function automatic int modulus(int md);
    case (md)
      1: return 16;
      2: return 256;
      default: return 512;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) samp[i] = '0;
      for (int i = 0; i < 3; i++) st[i] = '0;
      m_mode = 1; m_speed = SR; m_pos = 0; m_phase = 0; m_pwm = 0;
      m_paused = 0; m_led = 8'h00;
    end else begin
      m_p   = st[1] & ~st[2];
      m_led = led_of(m_mode, m_pos, m_pwm);
      m_pwm = (m_pwm + 1) % 256;
      if (m_p[6]) begin
        m_pos = 0; m_phase = 0; m_speed = SR; m_paused = 0;
      end else if (m_p[1] != m_p[2]) begin
        m_mode = m_p[1] ? (m_mode + 1) % 4 : (m_mode + 3) % 4;
        m_pos = 0; m_phase = 0;
      end else if (m_p[3] != m_p[4]) begin
        m_ns = m_p[3] ? m_speed + 1 : m_speed - 1;
        if (m_ns > 7) m_ns = 7;
        if (m_ns < 0) m_ns = 0;
        if (m_ns != m_speed) begin
          m_speed = m_ns; m_phase = 0;
        end
      end else if (m_p[5]) begin
        m_paused = !m_paused;
      end else if (!m_paused) begin
        m_phase++;
        if (m_phase == (1 << (TL - m_speed))) begin
          m_phase = 0;
          m_pos = (m_pos + 1) % modulus(m_mode);
        end
      end
      for (int b = 0; b < 7; b++)
        m_new[b] = (samp[1][b] != st[0][b] && samp[2][b] != st[0][b] &&
                    samp[3][b] != st[0][b]) ? ~st[0][b] : st[0][b];
      st[2] = st[1]; st[1] = st[0]; st[0] = m_new;
      samp[3] = samp[2]; samp[2] = samp[1]; samp[1] = samp[0]; samp[0] = btn;
    end
  end

  // ---------------- scoreboard: every cycle against the model ----------------
  always @(negedge clk) begin
    if (model_en && rst_n)
      check("cycle_model", {21'd0, led, mode, paused}, {21'd0, m_led, m_mode[1:0], m_paused});
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn(input logic [6:0] b, input int hold);
    btn = b;
    cycles(hold);
    btn = '0;
    cycles(12);
  endtask

  task automatic wait_led_change(input int limit, output int gap, output logic [7:0] val);
    logic [7:0] prev;
    prev = led;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (led == prev && gap < limit);
    val = led;
    if (led == prev) begin
      checks++;
      errors++;
      $display("FAIL led_change_timeout: led stuck at %0h after %0d cycles", led, gap);
    end
  endtask

  typedef struct {
    logic [6:0] b;
    int         hold;
    logic [1:0] exp_mode;
    logic       exp_paused;
  } vec_t;

  vec_t       vecs [14];
  logic [7:0] exp_sweep [16];
  int         n, gap, bad, hi;
  logic [7:0] v, pv;
  logic [6:0] rb;

  initial begin
    vecs[0]  = '{7'b0000010,  2, 2'd1, 1'b0};  // glitch rejected
    vecs[1]  = '{7'b0000010, 10, 2'd2, 1'b0};
    vecs[2]  = '{7'b0000010, 10, 2'd3, 1'b0};
    vecs[3]  = '{7'b0000010, 10, 2'd0, 1'b0};  // next wraps to OFF
    vecs[4]  = '{7'b0000100, 10, 2'd3, 1'b0};  // prev from OFF
    vecs[5]  = '{7'b0000110, 10, 2'd3, 1'b0};  // next+prev cancel
    vecs[6]  = '{7'b0100000, 10, 2'd3, 1'b1};
    vecs[7]  = '{7'b0000010, 10, 2'd0, 1'b1};  // paused kept across mode change
    vecs[8]  = '{7'b1000010, 10, 2'd0, 1'b0};  // restart wins over next
    vecs[9]  = '{7'b0000100, 10, 2'd3, 1'b0};
    vecs[10] = '{7'b0100000, 10, 2'd3, 1'b1};
    vecs[11] = '{7'b0100000, 10, 2'd3, 1'b0};
    vecs[12] = '{7'b0000010, 10, 2'd0, 1'b0};
    vecs[13] = '{7'b0000010, 10, 2'd1, 1'b0};
    exp_sweep = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                  8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    // 1. reset and free-running sweep
    cycles(2);
    check("rst_mode", {30'd0, mode}, 1);
    check("rst_led", {24'd0, led}, 0);
    check("rst_paused", {31'd0, paused}, 0);
    rst_n = 1'b1;
    model_en = 1;
    cycles(16);
    for (int i = 0; i <= 16; i++) begin
      check("sweep_step", {24'd0, led}, {24'd0, exp_sweep[i % 16]});
      if (i < 16) cycles(32);
    end

    // 2. table of button actions
    for (int i = 0; i < 14; i++) begin
      press_btn(vecs[i].b, vecs[i].hold);
      check("tbl_mode", {30'd0, mode}, {30'd0, vecs[i].exp_mode});
      check("tbl_paused", {31'd0, paused}, {31'd0, vecs[i].exp_paused});
    end

    // 3. press latency and first COUNT steps
    btn = 7'b0000010;
    n = 0;
    do begin cycles(1); n++; end while (mode == 2'd1 && n < 20);
    check("press_latency", n, 7);
    cycles(1);
    check("count_led_first", {24'd0, led}, 0);
    cycles(31);
    check("count_led_hold", {24'd0, led}, 0);
    cycles(1);
    check("count_led_step", {24'd0, led}, 1);
    btn = '0;
    cycles(12);

    // 4. speed saturation
    repeat (5) press_btn(7'b0001000, 8);
    wait_led_change(20, gap, pv);
    for (int k = 0; k < 4; k++) begin
      wait_led_change(20, gap, v);
      check("fast_gap", gap, 2);
      check("fast_inc", {24'd0, v}, {24'd0, 8'(pv + 8'd1)});
      pv = v;
    end
    repeat (8) press_btn(7'b0010000, 8);
    wait_led_change(600, gap, pv);
    wait_led_change(600, gap, v);
    check("slow_gap", gap, 256);
    check("slow_inc", {24'd0, v}, {24'd0, 8'(pv + 8'd1)});

    // 5. pause in COUNT at 0x05
    press_btn(7'b1000000, 8);
    n = 0;
    while (led != 8'h05 && n < 400) begin cycles(1); n++; end
    check("reach_5", {24'd0, led}, 5);
    cycles(2);
    press_btn(7'b0100000, 10);
    check("pause_on", {31'd0, paused}, 1);
    bad = 0;
    repeat (1000) begin cycles(1); if (led != 8'h05) bad++; end
    check("pause_hold", bad, 0);
    btn = 7'b0100000;
    n = 0;
    while (paused && n < 20) begin cycles(1); n++; end
    check("pause_off", {31'd0, paused}, 0);
    wait_led_change(40, gap, v);
    check("resume_val", {24'd0, v}, 6);
    btn = '0;
    cycles(12);

    // random button activity
    for (int r = 0; r < 30; r++) begin
      rb = {($urandom_range(0, 7) == 0), 6'($urandom_range(0, 63))};
      btn = rb;
      cycles($urandom_range(1, 12));
      btn = '0;
      cycles($urandom_range(1, 60));
    end
    cycles(12);

    // 6. breathe
    press_btn(7'b1000000, 8);
    for (int k = 0; k < 4; k++) if (mode != 2'd3) press_btn(7'b0000010, 8);
    check("breathe_mode", {30'd0, mode}, 3);
    bad = 0;
    repeat (10) begin cycles(1); if (led != 8'h00) bad++; end
    check("breathe_dark", bad, 0);
    n = 0;
    while (m_pos != 128 && n < 5000) begin cycles(1); n++; end
    press_btn(7'b0100000, 10);
    check("breathe_paused", {31'd0, paused}, 1);
    hi = 0;
    bad = 0;
    repeat (256) begin
      cycles(1);
      if (led == 8'hFF) hi++;
      else if (led != 8'h00) bad++;
    end
    check("breathe_duty", hi, 128);
    check("breathe_levels", bad, 0);

    // asynchronous reset mid-pattern
    n = 0;
    while (led != 8'hFF && n < 300) begin cycles(1); n++; end
    check("breathe_lit", {24'd0, led}, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    check("async_led", {24'd0, led}, 0);
    check("async_mode", {30'd0, mode}, 1);
    check("async_paused", {31'd0, paused}, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation did not complete, time=%0t limit=%0d", $time, 1000000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Board-level controller that sequences the 8-LED output through selectable display modes under push-button control.
- Modes: off, bouncing single LED, binary counter, PWM "breathe".
- Buttons are debounced; each press is turned into a one-cycle event.
- Sits between the top-level btn/led pins and the 25 MHz board clock; replaces a free-running pattern generator with a configurable, pausable one.

Parameters:
- DEBOUNCE_W, 16: debounce counter width; input must be stable 2^DEBOUNCE_W-1 cycles to register.
- TICK_LSB, 20: step period exponent; period = 2^(TICK_LSB-speed) cycles. Must be >= 8.
- PWM_W, 8: PWM counter width for breathe mode.
- SPEED_RST, 3: speed value after reset or restart (0..7).

Ports:
- clk  in  1  system clock (25 MHz on board)
- rst_n  in  1  asynchronous active-low reset
- btn  in  7  raw buttons, active-high. [0] unused, [1] next mode, [2] prev mode, [3] speed up, [4] speed down, [5] pause toggle, [6] restart
- led  out  8  registered LED drive, active-high
- mode  out  2  current mode: 0 OFF, 1 SWEEP, 2 COUNT, 3 BREATHE
- paused  out  1  high while pattern frozen

Behaviour:
- Reset (async assert, sync release): mode=SWEEP, speed=SPEED_RST, paused=0, led=0, pos=0, prescaler=0, debounce state=0.
- Debounce, per bit:
  - 2-FF synchroniser.
  - If sync != stable, the counter increments; when it reaches all-ones, stable<=sync and the counter clears.
  - If sync == stable, the counter clears.
  - press = rising edge of stable, exactly 1 cycle.
- Event priority, same cycle: restart > mode change > speed change > pause.
  - Restart: pos=0, prescaler=0, speed=SPEED_RST, paused=0; mode unchanged; all other events that cycle are ignored.
- Mode FSM:
  - next: OFF->SWEEP->COUNT->BREATHE->OFF.
  - prev: the reverse order.
  - next and prev in the same cycle: no change.
  - Any mode change clears pos and prescaler; paused is retained.
- Speed: up saturates at 7, down saturates at 0. Up and down together: no change. Any speed change clears the prescaler.
- Tick:
  - Prescaler counts while !paused.
  - When it equals 2^(TICK_LSB-speed)-1, it wraps to 0 and a 1-cycle tick fires.
  - While paused, prescaler and pos hold.
- pos advances on tick. It is 9 bits wide; each mode uses its low bits:
  - SWEEP: pos[3:0] wraps 15->0. idx = pos[3] ? 7-pos[2:0] : pos[2:0]. led = 1<<idx, so the sequence is 0..7 then 7..0.
  - COUNT: pos[7:0] wraps 255->0. led = pos[7:0].
  - BREATHE: pos[8:0] wraps 511->0. level = pos[8] ? ~pos[7:0] : pos[7:0]. PWM counter free-runs (also while paused). led = {8{pwm_cnt < level}}; level 0 gives fully off.
  - OFF: led = 0. pos still counts, but the value is don't-care.
- Output timing: led is registered, 1 cycle after state. mode and paused are direct register outputs.
- Press-to-effect latency: 2 sync + 2^DEBOUNCE_W-1 debounce + 1 edge + 1 state cycles.

Decomposition:
- Shared package led_ctrl_pkg holds:
  - mode enum: MODE_OFF, MODE_SWEEP, MODE_COUNT, MODE_BREATHE (2 bits).
  - button index constants: BTN_NEXT=1, BTN_PREV=2, BTN_UP=3, BTN_DN=4, BTN_PAUSE=5, BTN_RESTART=6.
- One sub-module, btn_debounce: parameter DEBOUNCE_W, ports clk, rst_n, din, stable, press. Instantiated once per button bit (7x).

Test Plan (bench uses DEBOUNCE_W=2, TICK_LSB=8; speed 3 gives a 32-cycle period):
1. Reset then free run:
   - mode=1, led=0 for one cycle.
   - Then led=0x01, changing every 32 cycles: 0x02, 0x04 ... 0x80, 0x80, 0x40 ... 0x01.
   - Verify the wrap after pos=15.
2. Debounce:
   - btn[1] glitch high for 2 cycles -> mode stays 1.
   - Hold 10 cycles -> mode=2 exactly once, led=0x00, then 0x01 after 32 cycles.
   - Release and press again -> mode=3.
3. Wrap and simultaneous:
   - prev pressed from mode 0 -> mode=3.
   - next+prev asserted together -> mode unchanged.
   - restart pressed with next together -> mode unchanged, pos=0, speed=3.
4. Speed saturation, in COUNT:
   - 5 speed-up presses -> speed=7, period 2 cycles, led increments every 2 cycles.
   - 8 speed-down presses -> speed=0, period 256 cycles.
5. Pause:
   - In COUNT at led=0x05, press btn[5] -> paused=1, led holds 0x05 for 1000 cycles.
   - Press again -> resumes at 0x06 after a full period.
6. Breathe and reset:
   - In mode 3 at pos=0, led=0 constantly.
   - At pos=128, led high for 128 of every 256 cycles.
   - Assert rst_n low mid-pattern -> led=0, mode=1, paused=0 immediately, without waiting for a clock edge.
